fp_addsub_sign_pipe: RTL and testbench

- Parametrised successor to the single-cycle FPU sign/sticky logic.
- Computes, for a floating-point add/sub, three results:
  - the result sign,
  - the alignment sticky bit,
  - the effective-subtract flag.
- Runs as a 3-stage valid/ready pipeline with backpressure.
- Sits ahead of the mantissa adder and normaliser; its outputs steer sign selection and rounding downstream.

---
 rtl/fp_sign_pkg.sv | 23 ++
 rtl/fp_sticky_calc.sv | 35 +++
 rtl/fp_addsub_sign_pipe.sv | 156 +++++++++++++++
 tb/tb_fp_addsub_sign_pipe.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_sign_pkg.sv
// Shared widths, operation encodings and the S2->S3 payload for the add/sub sign pipeline.
package fp_sign_pkg;

  localparam int unsigned EXP_W_DEF   = 8;
  localparam int unsigned FRAC_W_DEF  = 23;
  localparam int unsigned SHAMT_W_DEF = 8;
  // Payload shift field is sized for the widest supported SHAMT_W.
  localparam int unsigned SHAMT_MAX_W = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic                   sa;
    logic                   sb;
    logic [1:0]             op;
    logic                   sticky;
    logic [SHAMT_MAX_W-1:0] shamt;
    logic                   b_lt_a;
    logic                   b_eq_a;
  } s2_payload_t;

endpackage

// File: rtl/fp_sticky_calc.sv
// Alignment shift amount, smaller-operand select and sticky OR of the bits shifted out.
module fp_sticky_calc
  import fp_sign_pkg::*;
#(
  parameter int unsigned EXP_W   = EXP_W_DEF,
  parameter int unsigned FRAC_W  = FRAC_W_DEF,
  parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
  input  logic [EXP_W-1:0]   expa,
  input  logic [EXP_W-1:0]   expb,
  input  logic [FRAC_W:0]    manta,
  input  logic [FRAC_W:0]    mantb,
  output logic [SHAMT_W-1:0] shamt_c,
  output logic               sticky_c
);

  localparam int unsigned MANT_W = FRAC_W + 1;

  logic             a_small;
  logic [EXP_W-1:0] diff;
  logic [FRAC_W:0]  mant_s;

  // Equal exponents treat B as the smaller operand; SHAMT_W >= EXP_W so |diff| always fits.
  always_comb begin
    a_small  = (expa < expb);
    diff     = a_small ? (expb - expa) : (expa - expb);
    shamt_c  = SHAMT_W'(diff);
    mant_s   = a_small ? manta : mantb;
    sticky_c = 1'b0;
    for (int unsigned i = 0; i < MANT_W; i++) begin
      if (32'(diff) > i) sticky_c = sticky_c | mant_s[i];
    end
  end

endmodule

// File: rtl/fp_addsub_sign_pipe.sv
// 3-stage valid/ready pipeline producing result sign, alignment sticky and effective-subtract.
// Optional statistics counters are enabled with FP_SIGN_STATS_EN.
module fp_addsub_sign_pipe
  import fp_sign_pkg::*;
#(
  parameter int unsigned EXP_W   = EXP_W_DEF,
  parameter int unsigned FRAC_W  = FRAC_W_DEF,
  parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [EXP_W+FRAC_W:0]     opa,
  input  logic [EXP_W+FRAC_W:0]     opb,
  input  logic [1:0]                fpu_op,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sign,
  output logic                      out_sticky,
  output logic                      out_eff_sub,
  output logic [SHAMT_W-1:0]        out_shamt
`ifdef FP_SIGN_STATS_EN
  ,
  output logic [15:0]               stat_ops,
  output logic [15:0]               stat_effsub
`endif
);

  localparam int unsigned OP_W = 1 + EXP_W + FRAC_W;

  logic              s1_valid;
  logic [OP_W-1:0]   s1_opa;
  logic [OP_W-1:0]   s1_opb;
  logic [1:0]        s1_op;
  logic              s2_valid;
  s2_payload_t       s2_q;
  s2_payload_t       s2_d;
  logic              s2_load_c;
  logic              s3_load_c;
  logic [EXP_W-1:0]  expa;
  logic [EXP_W-1:0]  expb;
  logic [FRAC_W:0]   manta;
  logic [FRAC_W:0]   mantb;
  logic [SHAMT_W-1:0] shamt_c;
  logic              sticky_c;
  logic              sub_c;
  logic              eff_sub_c;
  logic              sign_c;
  logic              unused_c;

  // A stage may load when the stage after it is empty or draining this cycle.
  assign s3_load_c = !out_valid || out_ready;
  assign s2_load_c = !s2_valid || s3_load_c;
  assign in_ready  = !s1_valid || s2_load_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_opa   <= '0;
      s1_opb   <= '0;
      s1_op    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      s1_opa   <= opa;
      s1_opb   <= opb;
      s1_op    <= fpu_op;
    end
  end

  assign expa  = s1_opa[FRAC_W +: EXP_W];
  assign expb  = s1_opb[FRAC_W +: EXP_W];
  assign manta = {|expa, s1_opa[FRAC_W-1:0]};
  assign mantb = {|expb, s1_opb[FRAC_W-1:0]};

  fp_sticky_calc #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W),
    .SHAMT_W(SHAMT_W)
  ) u_sticky (
    .expa    (expa),
    .expb    (expb),
    .manta   (manta),
    .mantb   (mantb),
    .shamt_c (shamt_c),
    .sticky_c(sticky_c)
  );

  always_comb begin
    s2_d        = '0;
    s2_d.sa     = s1_opa[OP_W-1];
    s2_d.sb     = s1_opb[OP_W-1];
    s2_d.op     = s1_op;
    s2_d.sticky = sticky_c;
    s2_d.shamt  = SHAMT_MAX_W'(shamt_c);
    s2_d.b_lt_a = (s1_opb[OP_W-2:0] <  s1_opa[OP_W-2:0]);
    s2_d.b_eq_a = (s1_opb[OP_W-2:0] == s1_opa[OP_W-2:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_load_c) begin
      s2_valid <= s1_valid;
      s2_q     <= s2_d;
    end
  end

  // Exact cancellation yields +0; otherwise the larger magnitude decides the sign.
  always_comb begin
    sub_c     = (s2_q.op[0] == OP_SUB);
    eff_sub_c = s2_q.sa ^ s2_q.sb ^ sub_c;
    if (!eff_sub_c)      sign_c = s2_q.sa;
    else if (s2_q.b_eq_a) sign_c = 1'b0;
    else if (s2_q.b_lt_a) sign_c = s2_q.sa;
    else                  sign_c = s2_q.sb ^ sub_c;
  end

  assign unused_c = ^{s2_q.op[1], s2_q.shamt >> SHAMT_W};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_sign    <= 1'b0;
      out_sticky  <= 1'b0;
      out_eff_sub <= 1'b0;
      out_shamt   <= '0;
    end else if (s3_load_c) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_sign    <= sign_c;
        out_sticky  <= s2_q.sticky;
        out_eff_sub <= eff_sub_c;
        out_shamt   <= s2_q.shamt[SHAMT_W-1:0];
      end
    end
  end

`ifdef FP_SIGN_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops    <= '0;
      stat_effsub <= '0;
    end else begin
      if (in_valid && in_ready && (stat_ops != 16'hFFFF)) stat_ops <= stat_ops + 16'd1;
      if (out_valid && out_ready && out_eff_sub && (stat_effsub != 16'hFFFF))
        stat_effsub <= stat_effsub + 16'd1;
    end
  end
`else
  // Default build carries no statistics state.
`endif

endmodule

// File: tb/tb_fp_addsub_sign_pipe.sv
// Self-checking bench for fp_addsub_sign_pipe (single-precision defaults, optional FP_SIGN_STATS_EN).
module tb_fp_addsub_sign_pipe;
  import fp_sign_pkg::*;

  typedef struct packed {
    logic       sign;
    logic       sticky;
    logic       eff_sub;
    logic [7:0] shamt;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic [1:0]  fpu_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign;
  logic        out_sticky;
  logic        out_eff_sub;
  logic [7:0]  out_shamt;
`ifdef FP_SIGN_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_effsub;
`endif

  int   checks = 0;
  int   errors = 0;
  int   acc_count = 0;
  int   effsub_consumed = 0;
  res_t expq[$];

  fp_addsub_sign_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opa        (opa),
    .opb        (opb),
    .fpu_op     (fpu_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_sticky (out_sticky),
    .out_eff_sub(out_eff_sub),
    .out_shamt  (out_shamt)
`ifdef FP_SIGN_STATS_EN
    ,
    .stat_ops   (stat_ops),
    .stat_effsub(stat_effsub)
`endif
  );

  always #5 clk = ~clk;

  // Reference model built from the arithmetic definition of each result.
  function automatic res_t ref_model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    int unsigned       ea;
    int unsigned       eb;
    int unsigned       d;
    int unsigned       k;
    longint unsigned   ma;
    longint unsigned   mb;
    longint unsigned   sm;
    longint unsigned   maga;
    longint unsigned   magb;
    logic              sub;
    res_t              r;
    ea   = a[30:23];
    eb   = b[30:23];
    ma   = (ea != 0 ? 64'd8388608 : 64'd0) + 64'(a[22:0]);
    mb   = (eb != 0 ? 64'd8388608 : 64'd0) + 64'(b[22:0]);
    d    = (ea > eb) ? ea - eb : eb - ea;
    if (d > 255) d = 255;
    sm   = (ea < eb) ? ma : mb;
    k    = (d > 24) ? 24 : d;
    maga = 64'(a[30:0]);
    magb = 64'(b[30:0]);
    sub  = (op[0] == OP_SUB);
    r.shamt   = 8'(d);
    r.sticky  = ((sm % (64'd1 << k)) != 0);
    r.eff_sub = a[31] ^ b[31] ^ sub;
    if (!r.eff_sub)      r.sign = a[31];
    else if (magb == maga) r.sign = 1'b0;
    else if (magb < maga)  r.sign = a[31];
    else                   r.sign = b[31] ^ sub;
    return r;
  endfunction

  // One clock of stimulus; returns handshake outcomes and the sampled result.
  task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic ordy, output logic acc, output logic cons, output res_t got);
    @(negedge clk);
    in_valid  = iv;
    opa       = a;
    opb       = b;
    fpu_op    = op;
    out_ready = ordy;
    #1;
    acc  = iv && in_ready;
    cons = out_valid && ordy;
    got  = {out_sign, out_sticky, out_eff_sub, out_shamt};
    if (acc) begin
      expq.push_back(ref_model(a, b, op));
      acc_count++;
    end
    if (cons && out_eff_sub) effsub_consumed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    checks++;
    if ({out_sign, out_sticky, out_eff_sub, out_shamt} !== 11'd0) begin
      errors++;
      $display("FAIL reset_out: got %h required 000", {out_sign, out_sticky, out_eff_sub, out_shamt});
    end
`ifdef FP_SIGN_STATS_EN
    checks++;
    if (stat_ops !== 16'd0 || stat_effsub !== 16'd0) begin
      errors++;
      $display("FAIL reset_stats: got %h/%h required 0/0", stat_ops, stat_effsub);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] va[7];
    logic [31:0] vb[7];
    logic [1:0]  vo[7];
    res_t        ve[7];
    logic        acc;
    logic        cons;
    res_t        got;
    res_t        dump;
    int          lat;
    va = '{32'h40400000, 32'h3F800000, 32'hC0400000, 32'h40400000, 32'hBF800000, 32'h3F800000, 32'h4B800000};
    vb = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h40400000, 32'hBF800000, 32'h3F000001, 32'h3F800000};
    vo = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
    ve = '{{1'b0, 1'b0, 1'b1, 8'd1}, {1'b1, 1'b0, 1'b1, 8'd1}, {1'b1, 1'b0, 1'b1, 8'd1},
           {1'b0, 1'b0, 1'b1, 8'd0}, {1'b1, 1'b0, 1'b0, 8'd0}, {1'b0, 1'b1, 1'b0, 8'd1},
           {1'b0, 1'b1, 1'b0, 8'd24}};
    for (int v = 0; v < 7; v++) begin
      cycle(1'b1, va[v], vb[v], vo[v], 1'b1, acc, cons, got);
      checks++;
      if (acc !== 1'b1) begin
        errors++;
        $display("FAIL dir_accept[%0d]: accepted=%b required 1", v, acc);
      end
      lat = 0;
      for (int k = 1; k <= 8 && lat == 0; k++) begin
        cycle(1'b0, 32'd0, 32'd0, 2'd0, 1'b1, acc, cons, got);
        if (cons) begin
          lat = k;
          if (expq.size() != 0) dump = expq.pop_front();
          checks++;
          if (got !== ve[v]) begin
            errors++;
            $display("FAIL dir_result[%0d]: got %h required %h", v, got, ve[v]);
          end
        end
      end
      checks++;
      if (lat != 3) begin
        errors++;
        $display("FAIL dir_latency[%0d]: got %0d cycles required 3", v, lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        acc;
    logic        cons;
    res_t        got;
    res_t        held;
    res_t        exp;
    logic        prev_stall;
    int          sent;
    int          delivered;
    int          blocked;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
`ifdef FP_SIGN_STATS_EN
    int          base_ops;
    base_ops = int'(stat_ops);
`endif
    sent = 0; delivered = 0; blocked = 0; prev_stall = 1'b0; held = '0;
    for (int c = 0; c < 40 && delivered < 8; c++) begin
      a  = 32'h3F800000 + (32'(sent) << 21);
      b  = 32'h40000000 ^ (32'(sent) << 31) ^ 32'(sent * 3);
      op = 2'(sent & 1);
      cycle(sent < 8, a, b, op, !(c >= 4 && c <= 6), acc, cons, got);
      if (acc) sent++;
      if (sent < 8 && !acc && in_valid) blocked++;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || got !== held) begin
          errors++;
          $display("FAIL b2b_stable[%0d]: valid=%b got %h required 1/%h", c, out_valid, got, held);
        end
      end
      prev_stall = out_valid && !out_ready;
      held       = got;
      if (cons) begin
        delivered++;
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL b2b_out: unexpected result %h", got);
        end else begin
          exp = expq.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL b2b_out[%0d]: got %h required %h", delivered, got, exp);
          end
        end
      end
    end
    checks++;
    if (delivered != 8 || expq.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: delivered %0d pending %0d required 8/0", delivered, expq.size());
    end
    checks++;
    if (blocked != 3) begin
      errors++;
      $display("FAIL b2b_in_ready: blocked cycles %0d required 3", blocked);
    end
`ifdef FP_SIGN_STATS_EN
    checks++;
    if (int'(stat_ops) != base_ops + 8) begin
      errors++;
      $display("FAIL b2b_stat_ops: got %0d required %0d", stat_ops, base_ops + 8);
    end
`endif
  endtask

  task automatic test_random();
    logic        acc;
    logic        cons;
    res_t        got;
    res_t        exp;
    logic        have;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [1:0]  op;
    logic [7:0]  e;
    have = 1'b0; a = '0; b = '0; op = '0;
    for (int c = 0; c < 400; c++) begin
      if (!have && c < 340) begin
        a = $urandom;
        r = $urandom;
        case (r[1:0])
          2'd0:    b = $urandom;
          2'd1:    b = a;
          2'd2: begin
            e = a[30:23] + 8'(r[7:4]);
            b = {r[31], e, r[30:8]};
          end
          default: begin
            a[30:23] = 8'(r[6:2]);
            b = {r[31], 8'd0, r[30:8]};
          end
        endcase
        op   = r[11:10];
        have = 1'b1;
      end
      r = $urandom;
      cycle(have && r[1:0] != 2'd0, a, b, op, (c >= 340) || r[3:2] != 2'd0, acc, cons, got);
      if (acc) have = 1'b0;
      if (cons) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL rand_out: unexpected result %h", got);
        end else begin
          exp = expq.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL rand_out[%0d]: got %h required %h", c, got, exp);
          end
        end
      end
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: %0d results missing required 0", expq.size());
    end
`ifdef FP_SIGN_STATS_EN
    checks++;
    if (int'(stat_ops) != acc_count || int'(stat_effsub) != effsub_consumed) begin
      errors++;
      $display("FAIL rand_stats: got %0d/%0d required %0d/%0d", stat_ops, stat_effsub, acc_count, effsub_consumed);
    end
`endif
  endtask

  task automatic test_reset_inflight();
    logic acc;
    logic cons;
    res_t got;
    int   stale;
    cycle(1'b1, 32'h3F800000, 32'h40400000, 2'd1, 1'b1, acc, cons, got);
    cycle(1'b1, 32'hC0400000, 32'h3F800000, 2'd0, 1'b1, acc, cons, got);
    cycle(1'b0, 32'd0, 32'd0, 2'd0, 1'b0, acc, cons, got);
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_sign !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: valid/sign %b%b required 11", out_valid, out_sign);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || {out_sign, out_sticky, out_eff_sub, out_shamt} !== 11'd0) begin
      errors++;
      $display("FAIL rst_async: valid=%b out=%h required 0/000", out_valid,
               {out_sign, out_sticky, out_eff_sub, out_shamt});
    end
    expq.delete();
    acc_count = 0;
    effsub_consumed = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 32'd0, 32'd0, 2'd0, 1'b1, acc, cons, got);
      if (cons) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL rst_stale: %0d results after reset required 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
